// File: rtl/wb_write_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : wb_write_arbiter                                                  |
// | Brief   : Register-file write-port arbiter: pipeline writeback has priority,|
// |           multi-cycle results are queued and drained into idle cycles.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_reg,
  input  logic [31:0] i_pipe_data,
  input  logic        i_aux_valid,
  output logic        o_aux_ready,
  input  logic [4:0]  i_aux_reg,
  input  logic [31:0] i_aux_data,
  input  logic [4:0]  i_query_reg1,
  input  logic [4:0]  i_query_reg2,
  output logic        o_pending1,
  output logic        o_pending2,
  output logic        o_stall_req,
  output logic        o_reg_write,
  output logic [4:0]  o_write_reg,
  output logic [31:0] o_write_data,
  output logic        o_overrun
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);
  localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);

  logic [4:0]      r_fifo_reg  [DEPTH];
  logic [31:0]     r_fifo_data [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_SW-1:0] r_starve;
  logic            r_stall;
  logic            r_overrun;
  logic            r_reg_write;
  logic [4:0]      r_write_reg;
  logic [31:0]     r_write_data;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [c_SW-1:0] w_starve_nxt;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  assign o_aux_ready = (r_count != c_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = i_aux_valid && o_aux_ready;
  // Pop decision uses the registered count, so a just-pushed entry waits one edge.
  assign w_pop       = !i_pipe_valid && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_reg[r_wr_ptr]  <= i_aux_reg;
      r_fifo_data[r_wr_ptr] <= i_aux_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_CW'(1);
    end
  end

  // Write stage: register 0 targets are consumed but never enable the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (i_pipe_valid) begin
      r_reg_write  <= (i_pipe_reg != 5'd0);
      r_write_reg  <= i_pipe_reg;
      r_write_data <= i_pipe_data;
    end else if (w_pop) begin
      r_reg_write  <= (r_fifo_reg[r_rd_ptr] != 5'd0);
      r_write_reg  <= r_fifo_reg[r_rd_ptr];
      r_write_data <= r_fifo_data[r_rd_ptr];
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty)
      w_starve_nxt = '0;
    else if (i_pipe_valid && (r_starve != c_LIMIT))
      w_starve_nxt = r_starve + c_SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve  <= '0;
      r_stall   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_pop)
        r_stall <= 1'b0;
      else if (w_starve_nxt == c_LIMIT)
        r_stall <= 1'b1;
      if (i_pipe_valid && r_stall)
        r_overrun <= 1'b1;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [c_AW-1:0] w_offset;
      logic            w_live;
      assign w_offset   = c_AW'(gi) - r_rd_ptr;
      assign w_live     = ({1'b0, w_offset} < r_count);
      assign w_hit1[gi] = w_live && (r_fifo_reg[gi] == i_query_reg1);
      assign w_hit2[gi] = w_live && (r_fifo_reg[gi] == i_query_reg2);
    end
  endgenerate

  assign o_pending1   = (|w_hit1) && (i_query_reg1 != 5'd0);
  assign o_pending2   = (|w_hit2) && (i_query_reg2 != 5'd0);
  assign o_stall_req  = r_stall;
  assign o_overrun    = r_overrun;
  assign o_reg_write  = r_reg_write;
  assign o_write_reg  = r_write_reg;
  assign o_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_wb_write_arbiter                                               |
// | Brief   : Scoreboard bench for wb_write_arbiter against a queue model.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_wb_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_reg = '0;
  logic [31:0] pipe_data = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_reg = '0;
  logic [31:0] aux_data = '0;
  logic [4:0]  query1 = '0;
  logic [4:0]  query2 = '0;
  logic        pending1, pending2, stall_req, reg_write, overrun;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  ent_t m_q[$];
  ent_t exp_q[$];
  bit   m_stall = 0;
  bit   m_ovr   = 0;
  int   m_starve = 0;
  int   n_checks = 0;
  int   n_errs   = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_pipe_valid(pipe_valid), .i_pipe_reg(pipe_reg), .i_pipe_data(pipe_data),
    .i_aux_valid(aux_valid), .o_aux_ready(aux_ready),
    .i_aux_reg(aux_reg), .i_aux_data(aux_data),
    .i_query_reg1(query1), .i_query_reg2(query2),
    .o_pending1(pending1), .o_pending2(pending2),
    .o_stall_req(stall_req), .o_reg_write(reg_write),
    .o_write_reg(write_reg), .o_write_data(write_data),
    .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic bit m_pending(logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    foreach (m_q[i]) if (m_q[i].r == q) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every enabled write the DUT presents must match the next expected write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && reg_write) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_write: got reg %0d data %0h, expected no write", write_reg, write_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_reg", 32'(write_reg), 32'(e.r));
          chk("write_data", write_data, e.d);
        end
      end
    end
  end

  // One cycle: check registered outputs, drive inputs, check pending, advance model.
  task automatic cyc(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                     input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic [4:0] q1, input logic [4:0] q2);
    int   sz;
    bit   popped;
    ent_t e;
    @(negedge clk);
    chk("aux_ready", 32'(aux_ready), 32'(m_q.size() != DEPTH));
    chk("stall_req", 32'(stall_req), 32'(m_stall));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    aux_valid  = av; aux_reg  = ar; aux_data  = ad;
    query1     = q1; query2   = q2;
    #1;
    chk("pending1", 32'(pending1), 32'(m_pending(q1)));
    chk("pending2", 32'(pending2), 32'(m_pending(q2)));
    sz = m_q.size();
    popped = 0;
    if (pv) begin
      if (pr != 5'd0) exp_q.push_back('{r: pr, d: pd});
    end else if (sz > 0) begin
      e = m_q.pop_front();
      popped = 1;
      if (e.r != 5'd0) exp_q.push_back(e);
    end
    if (av && sz != DEPTH) m_q.push_back('{r: ar, d: ad});
    if (pv && m_stall) m_ovr = 1;
    if (popped || sz == 0) m_starve = 0;
    else if (pv && m_starve < STARVE_LIMIT) m_starve++;
    if (popped) m_stall = 0;
    else if (m_starve >= STARVE_LIMIT) m_stall = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted and released away from clock edges.
  task automatic reset_mid(input logic [4:0] q);
    @(negedge clk);
    #2;
    rst = 1'b1;
    pipe_valid = 0; aux_valid = 0; query1 = q; query2 = q;
    #1;
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_stall_req", 32'(stall_req), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_aux_ready", 32'(aux_ready), 1);
    chk("rst_pending1", 32'(pending1), 0);
    m_q.delete(); exp_q.delete();
    m_stall = 0; m_ovr = 0; m_starve = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #8;
    chk("init_reg_write", 32'(reg_write), 0);
    chk("init_aux_ready", 32'(aux_ready), 1);
    chk("init_stall_req", 32'(stall_req), 0);
    #4 rst = 1'b0;
    idle(2);

    // Pipeline only, then a register-0 writeback that must not enable the write.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    idle(2);

    // Fill the FIFO behind pipeline traffic, attempt a fifth push, then drain.
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 32'h100 + i, 1, 5'(8 + i), 32'hA000 + i, 9, 11);
    cyc(1, 2, 32'h200, 1, 12, 32'hBAD, 9, 12);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 9, 10);

    // Two queued entries, then simultaneous push and pop.
    cyc(1, 3, 32'h300, 1, 13, 32'hC0, 13, 14);
    cyc(1, 3, 32'h301, 1, 14, 32'hC1, 13, 14);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 5'(15 + i), 32'hC2 + i, 14, 16);
    idle(4);

    // Starvation: one entry waits behind STARVE_LIMIT pipeline writebacks.
    cyc(1, 4, 32'h400, 1, 20, 32'hD0, 20, 0);
    for (int i = 0; i < STARVE_LIMIT; i++) cyc(1, 4, 32'h401 + i, 0, 0, 0, 20, 0);
    idle(2);
    // Same again, but the pipeline ignores the stall request for two cycles.
    cyc(1, 6, 32'h500, 1, 21, 32'hE0, 21, 0);
    for (int i = 0; i < STARVE_LIMIT + 2; i++) cyc(1, 6, 32'h501 + i, 0, 0, 0, 21, 0);
    idle(3);

    // Reset mid-drain.
    for (int i = 0; i < 3; i++) cyc(1, 7, 32'h600 + i, 1, 5'(24 + i), 32'hF0 + i, 25, 0);
    cyc(0, 0, 0, 0, 0, 0, 25, 0);
    reset_mid(25);
    idle(4);

    // Randomized traffic with small register ranges to provoke scoreboard hits.
    for (int i = 0; i < 400; i++) begin
      logic pv;
      pv = m_stall ? 1'b0 : ($urandom_range(0, 99) < 55);
      cyc(pv, 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(DEPTH + 3);
    chk("writes_outstanding", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
